// File: rtl/argmax_result_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : argmax_result_responder_pkg
// Description : Shared defaults and FSM state encoding for the argmax responder.
// Revision    : 1.0 - initial release
// ============================================================================
package argmax_result_responder_pkg;

    localparam int c_NUM_CLASSES = 10;
    localparam int c_ACC_W       = 32;
    localparam int c_IDX_W       = 4;
    localparam int c_TIMEOUT     = 2000;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SCAN   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;
    localparam logic [1:0] c_ABORT  = 2'd3;

endpackage : argmax_result_responder_pkg
`default_nettype wire

// File: rtl/argmax_result_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : argmax_result_responder_if
// Description : Start/done handshake plus accumulator beat stream and results.
// Revision    : 1.0 - initial release
// ============================================================================
interface argmax_result_responder_if #(
    parameter int ACC_W = argmax_result_responder_pkg::c_ACC_W,
    parameter int IDX_W = argmax_result_responder_pkg::c_IDX_W
) ();

    logic             start;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_data;
    logic             acc_ready;
    logic             busy;
    logic [IDX_W-1:0] digit;
    logic [ACC_W-1:0] max_val;
    logic             done;
    logic             err;

    // Host / accumulator side
    modport master (
        output start, acc_valid, acc_data,
        input  acc_ready, busy, digit, max_val, done, err
    );

    // Responder side
    modport slave (
        input  start, acc_valid, acc_data,
        output acc_ready, busy, digit, max_val, done, err
    );

endinterface : argmax_result_responder_if
`default_nettype wire

// File: rtl/argmax_cmp_stage.sv
`default_nettype none
// ============================================================================
// Module      : argmax_cmp_stage
// Description : Registered running-max element; signed strict-greater, ties keep lower index.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_cmp_stage #(
    parameter int ACC_W = argmax_result_responder_pkg::c_ACC_W,
    parameter int IDX_W = argmax_result_responder_pkg::c_IDX_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_en,
    input  wire logic [ACC_W-1:0] i_value,
    input  wire logic [IDX_W-1:0] i_index,
    output logic      [ACC_W-1:0] o_best_val,
    output logic      [IDX_W-1:0] o_best_idx
);

    logic [ACC_W-1:0] r_best_val;
    logic [IDX_W-1:0] r_best_idx;
    logic             w_take;

    // i_clear makes the first beat of a scan load unconditionally
    assign w_take = i_en && (i_clear || ($signed(i_value) > $signed(r_best_val)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (w_take) begin
            r_best_val <= i_value;
            r_best_idx <= i_index;
        end
    end

    assign o_best_val = r_best_val;
    assign o_best_idx = r_best_idx;

endmodule : argmax_cmp_stage
`default_nettype wire

// File: rtl/argmax_result_responder.sv
`default_nettype none
// ============================================================================
// Module      : argmax_result_responder
// Description : Scans NUM_CLASSES accumulator beats after start, reports argmax with done/err.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_result_responder
    import argmax_result_responder_pkg::*;
#(
    parameter int NUM_CLASSES = c_NUM_CLASSES,
    parameter int ACC_W       = c_ACC_W,
    parameter int IDX_W       = c_IDX_W,
    parameter int TIMEOUT     = c_TIMEOUT
) (
    input wire logic clk,
    input wire logic rst,
    argmax_result_responder_if.slave io_bus
);

    localparam int               c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic [IDX_W-1:0]   r_digit;
    logic [ACC_W-1:0]   r_max_val;

    logic               w_scan;
    logic               w_accept;
    logic [ACC_W-1:0]   w_best_val;
    logic [IDX_W-1:0]   w_best_idx;

    assign w_scan   = (r_state == c_SCAN);
    assign w_accept = w_scan && io_bus.acc_valid;

    argmax_cmp_stage #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_idx == '0),
        .i_en       (w_accept),
        .i_value    (io_bus.acc_data),
        .i_index    (r_idx),
        .o_best_val (w_best_val),
        .o_best_idx (w_best_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_idx     <= '0;
            r_timer   <= '0;
            r_digit   <= '0;
            r_max_val <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (io_bus.start) begin
                        r_state <= c_SCAN;
                        r_idx   <= '0;
                        r_timer <= '0;
                    end
                end
                c_SCAN: begin
                    if (w_accept) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_timer <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_FINISH;
                        end
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                        if (r_timer == c_TMR_LAST) begin
                            r_state <= c_ABORT;
                        end
                    end
                end
                c_FINISH: begin
                    r_digit   <= w_best_idx;
                    r_max_val <= w_best_val;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // In FINISH the running-max registers already hold the final result, so the
    // outputs show it in the same cycle done is high and latch it on the way out.
    assign io_bus.digit     = (r_state == c_FINISH) ? w_best_idx : r_digit;
    assign io_bus.max_val   = (r_state == c_FINISH) ? w_best_val : r_max_val;
    assign io_bus.done      = (r_state == c_FINISH);
    assign io_bus.err       = (r_state == c_ABORT);
    assign io_bus.busy      = w_scan;
    assign io_bus.acc_ready = w_scan;

endmodule : argmax_result_responder
`default_nettype wire
